// File: rtl/lifo.sv
// Synchronous LIFO stack with registered pop data and full/empty status.
// Define LIFO_ERRFLAG_EN to add sticky overflow/underflow error outputs.
module lifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef LIFO_ERRFLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_m1;
    logic [AW-1:0]         push_addr;
    logic [AW-1:0]         top_addr;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_replace;

    // Request semantics: write and read are single-cycle requests sampled at
    // posedge; an accepted read presents the popped word on data_out after that
    // same edge. read+write on a non-empty stack replaces the top entry; on an
    // empty stack it degrades to a plain push. Requests that cannot be served
    // (write while full, read while empty) are dropped without side effects.
    assign count_m1   = count - CW'(1);
    assign push_addr  = count[AW-1:0];
    assign top_addr   = count_m1[AW-1:0];

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));

    assign do_push    = write && (read ? empty : !full);
    assign do_pop     = read && !write && !empty;
    assign do_replace = read && write && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            data_out <= '0;
        end else begin
            if (do_push) begin
                count <= count + CW'(1);
            end
            if (do_pop) begin
                count <= count_m1;
            end
            if (do_pop || do_replace) begin
                data_out <= mem[top_addr];
            end
        end
    end

    // Storage carries no reset; its contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_push) begin
                mem[push_addr] <= data_in;
            end else if (do_replace) begin
                mem[top_addr] <= data_in;
            end
        end
    end

`ifdef LIFO_ERRFLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write && !read && full) begin
                overflow <= 1'b1;
            end
            if (read && !write && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lifo.sv
// Self-checking bench for lifo: queue-based reference stack feeds expected
// queues; a monitor compares status every cycle and data on each accepted pop.
module tb_lifo;

    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          write   = 1'b0;
    logic          read    = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef LIFO_ERRFLAG_EN
    logic          overflow;
    logic          underflow;
`endif

    lifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .write    (write),
        .read     (read),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef LIFO_ERRFLAG_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] dout;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } stat_t;

    stat_t         stat_q[$];
    logic [DW-1:0] exp_q[$];

    // Reference model: a plain queue used as a stack.
    logic [DW-1:0] stk[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_unf  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
        stat_t s;
        @(negedge clk);
        reset   = rst;
        write   = w;
        read    = r;
        data_in = d;
        if (rst) begin
            stk.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else if (r && stk.size() > 0) begin
            m_dout = stk[stk.size()-1];
            exp_q.push_back(m_dout);
            if (w) stk[stk.size()-1] = d;
            else   void'(stk.pop_back());
        end else if (w && stk.size() < DEPTH) begin
            stk.push_back(d);
        end else begin
            if (w && !r) m_ovf = 1'b1;
            if (r && !w) m_unf = 1'b1;
        end
        s.dout  = m_dout;
        s.empty = (stk.size() == 0);
        s.full  = (stk.size() == DEPTH);
        s.ovf   = m_ovf;
        s.unf   = m_unf;
        stat_q.push_back(s);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    // Monitor: an accepted read (read while not empty) presents a word.
    always @(posedge clk) begin : monitor
        logic  fire;
        stat_t e;
        fire = !reset && read && !empty;
        #1;
        if (stat_q.size() > 0) begin
            e = stat_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.dout));
            check("empty", 32'(empty), 32'(e.empty));
            check("full", 32'(full), 32'(e.full));
`ifdef LIFO_ERRFLAG_EN
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("underflow", 32'(underflow), 32'(e.unf));
`endif
        end
        if (fire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no pop at %0t", data_out, $time);
            end else begin
                check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Push 7,4,3,2,6 then pop x3 -> 6,2,3
        push(4'd7); push(4'd4); push(4'd3); push(4'd2); push(4'd6);
        pop(); pop(); pop();
        // Push 9 then pop x3 -> 9,4,7, ends empty
        push(4'd9);
        pop(); pop(); pop();

        // Pop while empty: data_out holds
        pop(); pop();
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Fill to DEPTH, then 5 ignored writes, then drain
        for (int i = 0; i < DEPTH; i++) push(DW'(i + 1));
        for (int i = 0; i < 5; i++) push(DW'(4'hA + i));
        // Replace-top while full is legal
        cycle(1'b0, 1'b1, 1'b1, 4'hF);
        for (int i = 0; i < DEPTH; i++) pop();

        // read+write on empty behaves as a push
        cycle(1'b0, 1'b1, 1'b1, 4'h3);
        pop();

        // Reset, push 1,2, replace with 5 -> data_out 2, next pop 5
        cycle(1'b1, 1'b0, 1'b0, '0);
        push(4'd1); push(4'd2);
        cycle(1'b0, 1'b1, 1'b1, 4'd5);
        pop();
        // Reset mid-stream discards entries
        push(4'd8);
        cycle(1'b1, 1'b1, 1'b1, 4'd4);
        pop();

        // Randomized traffic with varying push/pop bias
        for (int ph = 0; ph < 6; ph++) begin
            int wb;
            wb = (ph % 3 == 0) ? 75 : ((ph % 3 == 1) ? 25 : 50);
            for (int i = 0; i < 120; i++) begin
                cycle($urandom_range(0, 79) == 0,
                      $urandom_range(0, 99) < wb,
                      $urandom_range(0, 99) < (100 - wb),
                      DW'($urandom_range(0, 15)));
            end
        end
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Let the monitor consume every queued expectation
        for (int i = 0; i < 20 && stat_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check("stat_q_drained", 32'(stat_q.size()), 32'd0);
        check("pop_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
